norm_result_collector: RTL

NORM_RESULT_COLLECTOR -- requirements
Module: norm_result_collector

---
 rtl/norm_result_collector.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/norm_result_collector.sv
// Four-lane result collector: per-lane FIFOs re-align skewed lane results by order and emit one
// packed word {A,B,C,D}. Define NORM_COLLECTOR_OVF_COUNT_EN to build the dropped-sample counter.
module norm_result_collector #(
  parameter int unsigned DATAWIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_valid_A,
  input  logic                         i_valid_B,
  input  logic                         i_valid_C,
  input  logic                         i_valid_D,
  input  logic [DATAWIDTH:0]           i_data_A,
  input  logic [DATAWIDTH:0]           i_data_B,
  input  logic [DATAWIDTH:0]           i_data_C,
  input  logic [DATAWIDTH:0]           i_data_D,
  input  logic                         i_ready,
  output logic                         o_valid,
  output logic [4*(DATAWIDTH+1)-1:0]   o_data,
  output logic                         o_ovf,
  output logic [15:0]                  o_ovf_count
);

  localparam int unsigned LW = DATAWIDTH + 1;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {StEmpty, StHold} state_e;

  // Lane index 3 is A, 0 is D, so the packed head array is already in output order.
  logic [3:0]          in_valid;
  logic [3:0][LW-1:0]  in_data;
  logic [3:0][LW-1:0]  head;
  logic [3:0]          lane_ne;
  logic [3:0]          lane_push;
  logic [3:0]          lane_ovf;
  logic                pop;

  state_e              state_q, state_d;
  logic [4*LW-1:0]     data_q, data_d;
  logic                ovf_q;

  assign in_valid = {i_valid_A, i_valid_B, i_valid_C, i_valid_D};
  assign in_data  = {i_data_A, i_data_B, i_data_C, i_data_D};

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [LW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          full;

    assign full         = (cnt_q == CW'(FIFO_DEPTH));
    assign lane_ne[l]   = (cnt_q != '0);
    // A full lane still accepts a push when the same edge pops it.
    assign lane_push[l] = in_valid[l] && (!full || pop);
    assign lane_ovf[l]  = in_valid[l] && full && !pop;
    assign head[l]      = mem_q[rd_q];

    always_ff @(posedge clk) begin
      if (lane_push[l]) begin
        mem_q[wr_q] <= in_data[l];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (lane_push[l]) wr_q <= wr_q + PW'(1);
        if (pop)          rd_q <= rd_q + PW'(1);
        case ({lane_push[l], pop})
          2'b10:   cnt_q <= cnt_q + CW'(1);
          2'b01:   cnt_q <= cnt_q - CW'(1);
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    pop     = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (&lane_ne) begin
          pop     = 1'b1;
          data_d  = head;
          state_d = StHold;
        end
      end
      StHold: begin
        if (i_ready) begin
          if (&lane_ne) begin
            pop    = 1'b1;
            data_d = head;
          end else begin
            state_d = StEmpty;
          end
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ovf_q   <= ovf_q | (|lane_ovf);
    end
  end

  assign o_valid = (state_q == StHold);
  assign o_data  = data_q;
  assign o_ovf   = ovf_q;

`ifdef NORM_COLLECTOR_OVF_COUNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;
  logic [2:0]  ovf_num;
  logic [16:0] ovf_sum;

  always_comb begin
    ovf_num   = 3'(lane_ovf[0]) + 3'(lane_ovf[1]) + 3'(lane_ovf[2]) + 3'(lane_ovf[3]);
    ovf_sum   = {1'b0, ovf_cnt_q} + 17'(ovf_num);
    ovf_cnt_d = ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign o_ovf_count = ovf_cnt_q;
`else
  assign o_ovf_count = 16'h0;
`endif

endmodule
